// File: rtl/halflife_pkg.sv
// Shared types and default widths for the half-life decay sequencer.
package halflife_pkg;

    localparam int W_DEF  = 4;
    localparam int PW_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_DECAY = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/halflife_period_timer.sv
// Counts ticks against a latched half-period and flags the expiring tick.
module halflife_period_timer #(
    parameter int PW = halflife_pkg::PW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          enable,
    input  logic [PW-1:0] period,
    output logic          expire
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] latch_q, latch_d;

    always_comb begin
        expire  = enable && (cnt_q == latch_q - PW'(1));
        cnt_d   = cnt_q;
        latch_d = latch_q;
        if (clear) begin
            cnt_d   = '0;
            latch_d = '0;
        end else if (load) begin
            cnt_d   = '0;
            // A zero period would never expire; run it as one tick.
            latch_d = (period == '0) ? PW'(1) : period;
        end else if (enable) begin
            cnt_d = expire ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            latch_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
        end
    end

endmodule

// File: rtl/halflife_sequencer.sv
// Half-life decay sequencer driving an external up/down counter.
// HL_AUTO_RESTART_EN: DONE lasts one cycle, then reloads automatically.
module halflife_sequencer #(
    parameter int W  = halflife_pkg::W_DEF,
    parameter int PW = halflife_pkg::PW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          tick,
    input  logic [W-1:0]  n0,
    input  logic [PW-1:0] half_period,
    output logic          cnt_load,
    output logic [W-1:0]  cnt_in,
    output logic          cnt_down,
    output logic          cnt_up,
    output logic          busy,
    output logic          done,
    output logic [3:0]    halvings
);

    import halflife_pkg::*;

    state_e       state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] pend_q, pend_d;
    logic [3:0]   halv_q, halv_d;
    logic         expire;

    halflife_period_timer #(.PW(PW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (abort),
        .load   (state_q == S_LOAD),
        .enable (state_q == S_WAIT && tick),
        .period (half_period),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        pend_d  = pend_q;
        halv_d  = halv_q;
        if (abort) begin
            state_d = S_IDLE;
            q_d     = '0;
            pend_d  = '0;
            halv_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    q_d     = n0;
                    pend_d  = '0;
                    halv_d  = '0;
                    state_d = (n0 != '0) ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    if (expire) begin
                        // Decay the larger half so a lone unit still decays.
                        pend_d  = q_q - (q_q >> 1);
                        halv_d  = (halv_q == 4'hF) ? halv_q : halv_q + 4'd1;
                        state_d = S_DECAY;
                    end
                end
                S_DECAY: begin
                    q_d    = q_q - W'(1);
                    pend_d = pend_q - W'(1);
                    if (pend_q == W'(1))
                        state_d = (q_q == W'(1)) ? S_DONE : S_WAIT;
                end
                S_DONE: begin
`ifdef HL_AUTO_RESTART_EN
                    state_d = S_LOAD;
`else
                    if (start) state_d = S_LOAD;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            pend_q  <= '0;
            halv_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pend_q  <= pend_d;
            halv_q  <= halv_d;
        end
    end

    assign cnt_load = (state_q == S_LOAD);
    assign cnt_in   = cnt_load ? n0 : '0;
    assign cnt_down = (state_q == S_DECAY);
    assign cnt_up   = 1'b0;
    assign busy     = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                      (state_q == S_DECAY);
    assign done     = (state_q == S_DONE);
    assign halvings = halv_q;

endmodule

// File: tb/tb_halflife_sequencer.sv
// Randomized bench for halflife_sequencer against a burst-level decay model.
module tb_halflife_sequencer;

    localparam int W  = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset, start, abort, tick;
    logic [W-1:0]  n0;
    logic [PW-1:0] half_period;
    logic          cnt_load, cnt_down, cnt_up, busy, done;
    logic [W-1:0]  cnt_in;
    logic [3:0]    halvings;

    int vectors     = 0;
    int miscompares = 0;
    int exp_b[$];
    int got_b[$];
    int gaps[$];

    always #5 clk = ~clk;

    halflife_sequencer #(.W(W), .PW(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .tick        (tick),
        .n0          (n0),
        .half_period (half_period),
        .cnt_load    (cnt_load),
        .cnt_in      (cnt_in),
        .cnt_down    (cnt_down),
        .cnt_up      (cnt_up),
        .busy        (busy),
        .done        (done),
        .halvings    (halvings)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each half-life removes ceil(q/2) units until nothing is left.
    function automatic void build_bursts(input int n);
        int q;
        exp_b.delete();
        q = n;
        while (q > 0) begin
            exp_b.push_back(q - q / 2);
            q = q / 2;
        end
    endfunction

    // Inputs apply to the cycle sampled at the following negedge.
    task automatic step(input logic t, input logic s, input logic a);
        @(posedge clk);
        #1;
        tick  = t;
        start = s;
        abort = a;
        @(negedge clk);
    endtask

    task automatic do_run(input int n, input int hp, input int pct);
        int   eff, cur, gap, total, nb;
        logic t, s, prev_wait, saw_done;
        build_bursts(n);
        eff = (hp == 0) ? 1 : hp;
        got_b.delete();
        gaps.delete();
        cur = 0; gap = 0; total = 0;
        prev_wait = 1'b0;
        saw_done  = 1'b0;
        n0 = W'(n);
        half_period = PW'(hp);
        step(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            t = ($urandom_range(99) < pct);
            s = prev_wait ? ($urandom_range(3) == 0) : 1'b0;
            step(t, s, 1'b0);
            if (cnt_load) chk("cnt_in", int'(cnt_in), n);
            prev_wait = busy && !cnt_load && !cnt_down;
            if (prev_wait && t) gap++;
            if (cnt_down) begin
                if (cur == 0) begin
                    gaps.push_back(gap);
                    gap = 0;
                end
                cur++;
                total++;
            end else if (cur > 0) begin
                got_b.push_back(cur);
                cur = 0;
            end
            if (done) begin
                saw_done = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(saw_done), 1);
        chk("burst_count", got_b.size(), exp_b.size());
        nb = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < nb; i++) chk("burst_len", got_b[i], exp_b[i]);
        foreach (gaps[i]) chk("wait_ticks", gaps[i], eff);
        chk("down_total", total, n);
        chk("halvings", int'(halvings), (exp_b.size() > 15) ? 15 : exp_b.size());
        chk("busy_done", int'(busy), 0);
        chk("cnt_up", int'(cnt_up), 0);
`ifdef HL_AUTO_RESTART_EN
        step(1'b0, 1'b0, 1'b0);
        chk("auto_load", int'(cnt_load), 1);
        chk("auto_done_1cyc", int'(done), 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("auto_abort_idle", int'(busy | done), 0);
`else
        step(1'b0, 1'b0, 1'b0);
        chk("done_hold", int'(done), 1);
`endif
    endtask

    task automatic abort_test();
        int   cur;
        logic found;
        n0 = 4'd12;
        half_period = 4'd1;
        step(1'b1, 1'b1, 1'b0);
        cur = 0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step(1'b1, 1'b0, 1'b0);
            cur = cnt_down ? cur + 1 : 0;
            if (cur == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach", int'(found), 1);
        step(1'b1, 1'b0, 1'b1);
        chk("abort_third_down", int'(cnt_down), 1);
        step(1'b1, 1'b0, 1'b0);
        chk("abort_down", int'(cnt_down), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_halv", int'(halvings), 0);
        chk("abort_done", int'(done), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("abort_idle_down", int'(cnt_down | cnt_load), 0);
        end
    endtask

    task automatic reset_test();
        logic found;
        n0 = 4'd8;
        half_period = 4'd3;
        step(1'b1, 1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, 1'b0, 1'b0);
            if (halvings == 4'd1 && busy && !cnt_down && !cnt_load) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reach_wait", int'(found), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_halv", int'(halvings), 0);
        chk("rst_strobes", int'(cnt_load | cnt_down | done), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_down", int'(cnt_down | busy), 0);
        reset = 1'b0;
        do_run(7, 2, 100);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick  = 1'b0;
        n0    = '0;
        half_period = '0;
        #3;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_load", int'(cnt_load), 0);
        chk("reset_down", int'(cnt_down), 0);
        chk("reset_up", int'(cnt_up), 0);
        chk("reset_cnt_in", int'(cnt_in), 0);
        chk("reset_halv", int'(halvings), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_run(12, 2, 100);
        do_run(0, 3, 100);
        do_run(5, 0, 100);
        do_run(3, 1, 100);
        abort_test();
        reset_test();
        for (int r = 0; r < 40; r++)
            do_run(int'($urandom_range(15)), int'($urandom_range(15)),
                   int'($urandom_range(100, 30)));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/halflife_sequencer.md
HALFLIFE_SEQUENCER -- requirements
Module: halflife_sequencer

Interface
REQ-001 Parameter W, default 4: width of the decay counter datapath and of n0/cnt_in.
REQ-002 Parameter PW, default 4: width of half_period and of the internal period counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a decay run; sampled in IDLE and DONE only.
REQ-006 abort  input  1  terminate any run and return to IDLE; has priority over start.
REQ-007 tick  input  1  time-base enable, one cycle wide per time unit.
REQ-008 n0  input  W  initial quantity, sampled in LOAD.
REQ-009 half_period  input  PW  ticks per half-life, sampled in LOAD; 0 is treated as 1.
REQ-010 cnt_load  output  1  load strobe to the up/down counter datapath.
REQ-011 cnt_in  output  W  load value to the counter; equals n0 while cnt_load=1, otherwise 0.
REQ-012 cnt_down  output  1  decrement strobe to the counter, one pulse per unit decayed.
REQ-013 cnt_up  output  1  tied 0.
REQ-014 busy  output  1  high in LOAD, WAIT and DECAY.
REQ-015 done  output  1  high in DONE.
REQ-016 halvings  output  4  half-lives elapsed in the current run, saturating at 15.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT, DECAY and DONE; the next state is registered and all outputs are decoded from registered state.
REQ-018 IDLE: start=1 and abort=0 -> LOAD.
REQ-019 LOAD (exactly one cycle): cnt_load=1; shadow q<=n0; period latch<=max(half_period,1); per_cnt<=0; halvings<=0; next WAIT if n0!=0, else DONE.
REQ-020 WAIT: each tick increments per_cnt; a tick with per_cnt==latch-1 SHALL set per_cnt<=0 and pend<=q-(q>>1), then go to DECAY.
REQ-021 DECAY: cnt_down=1 every cycle; q and pend each decrement by 1 per cycle; halvings increments once on entry (saturating).
REQ-022 DECAY exit: in the cycle with pend==1, next state is DONE if q==1, else WAIT.
REQ-023 Ticks arriving in LOAD, DECAY, DONE or IDLE SHALL be ignored.
REQ-024 Total cnt_down pulses per run SHALL equal n0; q never underflows, and q==1 decays to 0 in one pulse.
REQ-025 DONE: done=1 until start (-> LOAD) or abort (-> IDLE).
REQ-026 start while busy SHALL be ignored.
REQ-027 abort in any state SHALL force IDLE on the next edge, deasserting cnt_load and cnt_down from that edge; q, pend, per_cnt and halvings are cleared.
REQ-028 start and abort in the same cycle: abort wins.

Reset
REQ-029 reset=1 SHALL immediately force IDLE with every output 0 and q, pend, per_cnt and halvings at 0, independent of clk.
REQ-030 Reset assertion mid-run abandons the run; no counter strobes are issued after reset asserts.

Configuration
REQ-031 Macro HL_AUTO_RESTART_EN defined: DONE lasts exactly one cycle and then enters LOAD automatically, re-sampling n0 and half_period; abort still exits to IDLE.
REQ-032 Macro HL_AUTO_RESTART_EN undefined: DONE holds as described in REQ-025.

Structure
REQ-033 Package halflife_pkg SHALL hold the state enum and the default values of W and PW.
REQ-034 Sub-module halflife_period_timer SHALL hold per_cnt, the period latch and expiry detection, with inputs clear and enable and output expire.

Verification
REQ-035 n0=12, half_period=2, tick every cycle -> down bursts of 6, 3, 2, 1; done=1; halvings=4; 12 cnt_down pulses in total.
REQ-036 n0=0, start -> one LOAD cycle (cnt_load=1, cnt_in=0), then DONE with no cnt_down and halvings=0.
REQ-037 half_period=0, n0=5, tick every cycle -> each WAIT lasts one tick; bursts of 3, 1, 1.
REQ-038 abort during the third cnt_down of a burst -> no further cnt_down; IDLE next cycle; busy=0 and halvings=0.
REQ-039 Reset asserted asynchronously mid-WAIT -> outputs go to 0 without a clock edge; a new start after release runs normally.
REQ-040 With HL_AUTO_RESTART_EN, n0=3, half_period=1 -> the run completes, done is high for one cycle, and cnt_load=1 on the next cycle.
